// File: rtl/axi_burst_ram_pkg.sv
// Shared types and AXI encodings for the burst RAM slave.
// Both FSMs use them, and so does the bench.
package axi_burst_ram_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // WRAP has no wrap boundary here. It advances exactly like INCR.
    function automatic logic idx_step(input logic [1:0] burst);
        case (burst)
            BURST_FIXED:            return 1'b0;
            BURST_INCR, BURST_WRAP: return 1'b1;
            default:                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_ram_if.sv
// Slave-side AXI4 bus (64-bit data, no IDs) for axi_burst_ram.
// Also carries the sideband fields that the RAM ignores.
interface axi_burst_ram_if;
    import axi_burst_ram_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awregion;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic                  awvalid;
    logic                  awready;

    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arregion;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arvalid;
    logic                  arready;

    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awregion, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arregion, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awregion, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arregion, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_burst_ram_ram_dp_bytewrite.sv
// Simple dual-port RAM with one synchronous read port and one byte-enable write port.
// The read is read-first, so a read and a write to the same word return the old data.
module ram_dp_bytewrite #(
    parameter int IDX_W = 12,
    parameter int BYTES = 8
) (
    input  logic                  clk,
    input  logic [BYTES-1:0]      we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [BYTES-1:0][7:0] wdata,
    input  logic                  ren,
    input  logic [IDX_W-1:0]      raddr,
    output logic [BYTES-1:0][7:0] rdata
);

    logic [BYTES-1:0][7:0] mem [2**IDX_W];
    logic [BYTES-1:0][7:0] rdata_q;

    // rdata_q changes only when ren is high, so a stalled beat keeps its value.
    always_ff @(posedge clk) begin
        if (ren) rdata_q <= mem[raddr];
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) mem[waddr][i] <= wdata[i];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 burst RAM slave with independent read and write FSMs.
// A burst ends on wlast or on the arlen count. FIXED holds the index; INCR and WRAP advance it.
module axi_burst_ram
    import axi_burst_ram_pkg::*;
#(
    parameter int MEM_INDEX_WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    axi_burst_ram_if.slave  s_axi_ram
);

    localparam int IW = MEM_INDEX_WIDTH;

    r_state_t          r_state_q, r_state_d;
    logic [IW-1:0]     r_idx_q, r_idx_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_step_q, r_step_d;
    w_state_t          w_state_q, w_state_d;
    logic [IW-1:0]     w_idx_q, w_idx_d;
    logic              w_step_q, w_step_d;

    logic              ar_hs, r_hs, aw_hs, w_hs;
    logic [AXI_STRB_W-1:0] ram_we;
    logic [AXI_DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        r_idx_q  <= r_idx_d;
        r_cnt_q  <= r_cnt_d;
        r_step_q <= r_step_d;
        w_idx_q  <= w_idx_d;
        w_step_q <= w_step_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_step_d  = r_step_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_state_d = R_BURST;
                r_idx_d   = s_axi_ram.araddr[IW+2:3];
                r_cnt_d   = s_axi_ram.arlen;
                r_step_d  = idx_step(s_axi_ram.arburst);
            end
            R_BURST: if (r_hs) begin
                r_idx_d = r_idx_q + {{(IW-1){1'b0}}, r_step_q};
                r_cnt_d = r_cnt_q - 8'd1;
                if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_step_d  = w_step_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_state_d = W_DATA;
                w_idx_d   = s_axi_ram.awaddr[IW+2:3];
                w_step_d  = idx_step(s_axi_ram.awburst);
            end
            W_DATA: if (w_hs) begin
                w_idx_d = w_idx_q + {{(IW-1){1'b0}}, w_step_q};
                if (s_axi_ram.wlast) w_state_d = W_RESP;
            end
            W_RESP: if (s_axi_ram.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_ram.arready = (r_state_q == R_IDLE);
        s_axi_ram.rvalid  = (r_state_q == R_BURST);
        s_axi_ram.rlast   = (r_state_q == R_BURST) && (r_cnt_q == 8'd0);
        s_axi_ram.rresp   = RESP_OKAY;
        s_axi_ram.rdata   = ram_rdata;
        s_axi_ram.awready = (w_state_q == W_IDLE);
        s_axi_ram.wready  = (w_state_q == W_DATA);
        s_axi_ram.bvalid  = (w_state_q == W_RESP);
        s_axi_ram.bresp   = RESP_OKAY;
    end

    assign ar_hs = s_axi_ram.arvalid && (r_state_q == R_IDLE);
    assign r_hs  = s_axi_ram.rready  && (r_state_q == R_BURST);
    assign aw_hs = s_axi_ram.awvalid && (w_state_q == W_IDLE);
    assign w_hs  = s_axi_ram.wvalid  && (w_state_q == W_DATA);

    // A beat accepted in the reset cycle must not land in memory.
    assign ram_we = (w_hs && !rst) ? s_axi_ram.wstrb : '0;

    // The read port is addressed with the next index, so the following beat is ready one cycle later.
    ram_dp_bytewrite #(.IDX_W(IW), .BYTES(AXI_STRB_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_idx_q),
        .wdata (s_axi_ram.wdata),
        .ren   (ar_hs || r_hs),
        .raddr (r_idx_d),
        .rdata (ram_rdata)
    );

    logic unused_ok;
    assign unused_ok = ^{s_axi_ram.awaddr[AXI_ADDR_W-1:IW+3], s_axi_ram.awaddr[2:0],
                         s_axi_ram.araddr[AXI_ADDR_W-1:IW+3], s_axi_ram.araddr[2:0],
                         s_axi_ram.awlen, s_axi_ram.awsize, s_axi_ram.arsize,
                         s_axi_ram.awregion, s_axi_ram.awlock, s_axi_ram.awcache,
                         s_axi_ram.awprot, s_axi_ram.awqos,
                         s_axi_ram.arregion, s_axi_ram.arlock, s_axi_ram.arcache,
                         s_axi_ram.arprot, s_axi_ram.arqos};

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram. Every expected word comes from the dv() pattern generator
// or from hand-derived merges. Inputs change and outputs are sampled on the falling edge.
module tb_axi_burst_ram;
    import axi_burst_ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_burst_ram_if bus ();

    axi_burst_ram #(.MEM_INDEX_WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi_ram (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] ex [16];
    logic [63:0] rq [$];
    logic [15:0] rl;
    int          stall_bad, resp_bad;
    logic        first_rv;
    logic [63:0] t0, t1;

    function automatic logic [63:0] dv(input logic [7:0] tag, input int i);
        return {tag, 8'(i), 16'hC0DE, ~tag, 8'(i), 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                      input int nb, input string tag);
        int n;
        @(negedge clk);
        bus.awaddr = a; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 20) begin @(negedge clk); n++; end
        chk({tag, " awready"}, 64'(bus.awready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == nb - 1); bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 20) begin @(negedge clk); n++; end
            if (!bus.wready) chk({tag, " wready"}, 64'(bus.wready), 64'd1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, " bvalid"}, 64'(bus.bvalid), 64'd1);
        chk({tag, " bresp"}, 64'(bus.bresp), 64'd0);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                      input logic [7:0] pat, input int per, input string tag);
        int n;
        logic ps;
        logic [63:0] pd;
        rq.delete(); rl = '0; stall_bad = 0; resp_bad = 0; ps = 1'b0; pd = '0;
        @(negedge clk);
        bus.araddr = a; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        chk({tag, " arready"}, 64'(bus.arready), 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        first_rv = bus.rvalid;
        n = 0;
        while (n < 200) begin
            bus.rready = pat[n % per];
            if (bus.rvalid) begin
                if (ps && bus.rdata !== pd) stall_bad++;
                if (bus.rresp !== 2'b00) resp_bad++;
                if (bus.rready) begin
                    if (rq.size() < 16) rl[rq.size()] = bus.rlast;
                    rq.push_back(bus.rdata);
                    ps = 1'b0;
                    if (bus.rlast) break;
                end else begin
                    ps = 1'b1; pd = bus.rdata;
                end
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.rready = 1'b0;
        chk({tag, " rvalid low after rlast"}, 64'(bus.rvalid), 64'd0);
    endtask

    task automatic chk_rd(input string tag, input int nexp);
        chk({tag, " first rvalid"}, 64'(first_rv), 64'd1);
        chk({tag, " beats"}, 64'(rq.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < rq.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), rq[i], ex[i]);
        chk({tag, " rlast"}, 64'(rl), 64'(16'd1 << (nexp - 1)));
        chk({tag, " stall stable"}, 64'(stall_bad), 64'd0);
        chk({tag, " rresp"}, 64'(resp_bad), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b101; bus.awburst = BURST_INCR;
        bus.awregion = 4'hF; bus.awlock = 1'b1; bus.awcache = 4'hF; bus.awprot = 3'h7; bus.awqos = 4'hF;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = BURST_INCR;
        bus.arregion = 4'hA; bus.arlock = 1'b1; bus.arcache = 4'h5; bus.arprot = 3'h2; bus.arqos = 4'h9;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst arready", 64'(bus.arready), 64'd1);
        chk("rst awready", 64'(bus.awready), 64'd1);
        chk("rst wready",  64'(bus.wready),  64'd0);
        chk("rst rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst rlast",   64'(bus.rlast),   64'd0);
        chk("rst bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst resp",    64'({bus.rresp, bus.bresp}), 64'd0);

        // Preload words 0x20..0x23 and read them back-to-back.
        for (int i = 0; i < 4; i++) begin wd[i] = dv(8'hA0, i); ws[i] = 8'hFF; ex[i] = dv(8'hA0, i); end
        wr(32'h100, 8'd3, BURST_INCR, 4, "preA");
        rd(32'h100, 8'd3, BURST_INCR, 8'hFF, 1, "rdA");
        chk_rd("rdA", 4);

        // Partial strobes on the second beat merge with the old word.
        wd[0] = dv(8'h0D, 0); wd[1] = dv(8'h0D, 1); ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr(32'h40, 8'd1, BURST_INCR, 2, "old35");
        wd[0] = dv(8'hD0, 0); wd[1] = dv(8'hD0, 1); ws[0] = 8'hFF; ws[1] = 8'h0F;
        wr(32'h40, 8'd1, BURST_INCR, 2, "w35");
        t0 = dv(8'h0D, 1); t1 = dv(8'hD0, 1);
        ex[0] = dv(8'hD0, 0); ex[1] = {t0[63:32], t1[31:0]};
        rd(32'h40, 8'd1, BURST_INCR, 8'hFF, 1, "r35");
        chk_rd("r35", 2);

        // rready pattern 1,0,0 repeating.
        for (int i = 0; i < 4; i++) ex[i] = dv(8'hA0, i);
        rd(32'h100, 8'd3, BURST_INCR, 8'b0000_0001, 3, "stall");
        chk_rd("stall", 4);

        // The index wraps from 0xFFF to word 0.
        wd[0] = dv(8'hEE, 0); ws[0] = 8'hFF;
        wr(32'h7FF8, 8'd0, BURST_INCR, 1, "top");
        wd[0] = dv(8'h11, 0);
        wr(32'h0, 8'd0, BURST_INCR, 1, "zero");
        ex[0] = dv(8'hEE, 0); ex[1] = dv(8'h11, 0);
        rd(32'h7FF8, 8'd1, BURST_INCR, 8'hFF, 1, "wrap");
        chk_rd("wrap", 2);

        // High address bits and byte offset are ignored; WRAP and FIXED behaviour.
        ex[0] = dv(8'hA0, 0);
        rd(32'h8000_0105, 8'd0, BURST_INCR, 8'hFF, 1, "hiaddr");
        chk_rd("hiaddr", 1);
        ex[0] = dv(8'hA0, 1); ex[1] = dv(8'hA0, 2);
        rd(32'h108, 8'd1, BURST_WRAP, 8'hFF, 1, "wrapburst");
        chk_rd("wrapburst", 2);
        for (int i = 0; i < 3; i++) ex[i] = dv(8'hA0, 0);
        rd(32'h100, 8'd2, BURST_FIXED, 8'hFF, 1, "fixr");
        chk_rd("fixr", 3);
        wd[0] = dv(8'hF0, 0); wd[1] = dv(8'hF0, 1); ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr(32'h208, 8'd1, BURST_FIXED, 2, "fixw");
        ex[0] = dv(8'hF0, 1);
        rd(32'h208, 8'd0, BURST_INCR, 8'hFF, 1, "fixw rb");
        chk_rd("fixw rb", 1);

        // wlast after 2 beats ends a burst announced with awlen=7.
        wd[0] = dv(8'hE0, 0); wd[1] = dv(8'hE0, 1);
        wr(32'h300, 8'd7, BURST_INCR, 2, "early");
        ex[0] = dv(8'hE0, 0); ex[1] = dv(8'hE0, 1);
        rd(32'h300, 8'd1, BURST_INCR, 8'hFF, 1, "early rb");
        chk_rd("early rb", 2);

        // Concurrent overlapping read and write, then reset mid-burst.
        for (int i = 0; i < 8; i++) begin wd[i] = dv(8'h50, i); ws[i] = 8'hFF; end
        wr(32'h400, 8'd7, BURST_INCR, 8, "pre38");
        @(negedge clk);
        bus.awaddr = 32'h400; bus.awlen = 8'd7; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
        chk("c38 awready", 64'(bus.awready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wdata = dv(8'h4E, 0); bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        bus.araddr = 32'h400; bus.arlen = 8'd7; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        chk("c38 wready", 64'(bus.wready), 64'd1);
        chk("c38 arready", 64'(bus.arready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.arvalid = 1'b0; bus.rready = 1'b1;
            chk($sformatf("c38 rvalid%0d", k), 64'(bus.rvalid), 64'd1);
            chk($sformatf("c38 rdata%0d", k), bus.rdata, dv(8'h50, k - 1));
            bus.wdata = dv(8'h4E, k);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("c38 rst rvalid",  64'(bus.rvalid),  64'd0);
        chk("c38 rst rlast",   64'(bus.rlast),   64'd0);
        chk("c38 rst bvalid",  64'(bus.bvalid),  64'd0);
        chk("c38 rst wready",  64'(bus.wready),  64'd0);
        chk("c38 rst arready", 64'(bus.arready), 64'd1);
        chk("c38 rst awready", 64'(bus.awready), 64'd1);
        rst = 1'b0; bus.wvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < 8; i++) ex[i] = (i < 3) ? dv(8'h4E, i) : dv(8'h50, i);
        rd(32'h400, 8'd7, BURST_INCR, 8'hFF, 1, "post38");
        chk_rd("post38", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_ram.md
AXI_BURST_RAM -- requirements
Module: axi_burst_ram

Interface
REQ-001 The block SHALL have parameter MEM_INDEX_WIDTH, default 12, meaning log2 of memory depth in 64-bit words (4096 words, 32 KiB).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have AW-channel ports, one per line: s_axi_ram_awaddr in 32; s_axi_ram_awlen in 8; s_axi_ram_awsize in 3; s_axi_ram_awburst in 2; s_axi_ram_awvalid in 1; s_axi_ram_awready out 1.
REQ-005 The block SHALL have W-channel ports, one per line: s_axi_ram_wdata in 64; s_axi_ram_wstrb in 8; s_axi_ram_wlast in 1; s_axi_ram_wvalid in 1; s_axi_ram_wready out 1.
REQ-006 The block SHALL have B-channel ports, one per line: s_axi_ram_bresp out 2; s_axi_ram_bvalid out 1; s_axi_ram_bready in 1.
REQ-007 The block SHALL have AR-channel ports, one per line: s_axi_ram_araddr in 32; s_axi_ram_arlen in 8; s_axi_ram_arsize in 3; s_axi_ram_arburst in 2; s_axi_ram_arvalid in 1; s_axi_ram_arready out 1.
REQ-008 The block SHALL have R-channel ports, one per line: s_axi_ram_rdata out 64; s_axi_ram_rresp out 2; s_axi_ram_rlast out 1; s_axi_ram_rvalid out 1; s_axi_ram_rready in 1.
REQ-009 The block SHALL accept and ignore the region, lock, cache, prot and qos inputs on AW and AR; it SHALL have no ID signals.

Function
REQ-010 The word index SHALL be addr[MEM_INDEX_WIDTH+2:3]; addr[2:0] and addr bits above the index SHALL be ignored.
REQ-011 The read FSM SHALL have states R_IDLE and R_BURST.
REQ-012 In R_IDLE, arready SHALL be 1; an AR handshake SHALL latch the index and arlen into a beat counter and enter R_BURST.
REQ-013 In R_BURST, arready SHALL be 0.
REQ-014 The first rvalid SHALL assert exactly 1 cycle after the AR handshake.
REQ-015 With rready held high, beats SHALL be back-to-back, arlen+1 beats total.
REQ-016 rdata SHALL be mem[index] and SHALL stay stable while rvalid=1 and rready=0.
REQ-017 On each R handshake, the index SHALL increment (INCR, and WRAP treated as INCR) or hold (FIXED), and the counter SHALL decrement.
REQ-018 rlast SHALL be 1 only on the beat where the counter is 0; its handshake SHALL return the read FSM to R_IDLE.
REQ-019 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-020 In W_IDLE, awready SHALL be 1; an AW handshake SHALL latch the index and enter W_DATA.
REQ-021 In W_DATA, wready SHALL be 1; each W handshake SHALL write the bytes of mem[index] selected by wstrb (wstrb[i] maps to bits 8i+7:8i) and advance the index per REQ-017.
REQ-022 The handshake with wlast=1 SHALL end the burst, regardless of awlen, and enter W_RESP.
REQ-023 In W_RESP, bvalid SHALL be 1 with bresp=2'b00; a B handshake SHALL return the write FSM to W_IDLE.
REQ-024 rresp SHALL always be 2'b00.
REQ-025 awsize/arsize other than 3'b011 SHALL be treated as 3'b011.
REQ-026 The index SHALL wrap modulo 2**MEM_INDEX_WIDTH at the top of memory.
REQ-027 The read and write FSMs SHALL be independent and SHALL be able to run concurrently.
REQ-028 When a write and a read hit the same word in the same cycle, the read SHALL return the pre-write data.

Reset
REQ-029 Reset SHALL put both FSMs in idle; outputs after reset: arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0, rresp=0, bresp=0.
REQ-030 Reset mid-burst SHALL abort the burst, with rvalid/bvalid low the next cycle and no further writes.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 AXI burst-type encodings (FIXED=0, INCR=1, WRAP=2) and the OKAY response SHALL be defines in shared axi.vh; the port list SHALL use the existing AXI slave interface macro, 64-bit data.
REQ-033 Storage SHALL be one sub-module, ram_dp_bytewrite: one synchronous read port, one byte-enable write port, parameterised depth.

Verification
REQ-034 Write araddr=0x100, arlen=3 after preloading words 0x20..0x23 with A0..A3, rready=1 -> rvalid from cycle+1, A0..A3 on 4 consecutive cycles, rlast on A3.
REQ-035 AW 0x40 awlen=1; W D0 strb 0xFF, then D1 strb 0x0F with wlast -> bvalid, bresp=0; readback word 0x08=D0, word 0x09 = upper 32 bits old, lower 32 bits from D1.
REQ-036 Read burst arlen=3 with rready toggling 1,0,0,1,... -> rdata constant during stalls, exactly 4 beats, no beat lost or duplicated.
REQ-037 Burst starting at the last word (index 0xFFF), arlen=1 -> second beat returns word 0.
REQ-038 Concurrent 8-beat read and write on overlapping words, then assert rst mid-burst -> all valids low the next cycle, arready=awready=1, and a subsequent read returns the partially written data.
